// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared SAP widths and checksum helper for the program loader
//
// Purpose : widths shared by the control unit, the datapath and the loader,
//           plus the 8-bit wrap-around checksum test used at the end of a load.
// Ports   : none (package).
package prog_loader_pkg;

  // RAM address width; also the width of the IR operand field.
  localparam int SAP_ADDR_W = 8;
  // RAM word width: {opcode, operand}.
  localparam int SAP_WORD_W = 16;

  // A load is good when the running sum plus the CSUM byte wraps to zero.
  function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] csum);
    logic [7:0] total;
    total = sum + csum;
    return (total == 8'h00);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial-link program loader writing words into SAP RAM
//
// Purpose : accepts LEN, LEN x {HI, LO}, CSUM over a valid/ready byte link,
//           writes each word to RAM and holds the CPU in reset until a load
//           completes with a good checksum.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           in_data/in_valid/in_ready - serial-link byte handshake
//           reload          - restart a load from DONE or ERR
//           ram_we/ram_addr/ram_wdata - RAM write port
//           cpu_rst         - registered reset to the control unit and datapath
//           done/err        - result of the last load
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                ADDR_W    = SAP_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [SAP_WORD_W-1:0] ram_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_LEN,
    S_HI,
    S_LO,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state, state_next;
  logic [7:0]        count;
  logic [7:0]        sum;
  logic [7:0]        hi_byte;
  logic [ADDR_W-1:0] addr;
  logic              accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LEN;
      cpu_rst   <= 1'b1;
      count     <= 8'h00;
      sum       <= 8'h00;
      hi_byte   <= 8'h00;
      addr      <= BASE_ADDR;
      ram_addr  <= BASE_ADDR;
      ram_wdata <= '0;
    end else begin
      state   <= state_next;
      // Registered from the next state so the CPU sees a clean edge.
      cpu_rst <= (state_next != S_DONE);
      case (state)
        S_LEN: begin
          if (accept) begin
            count <= in_data;
            sum   <= in_data;
            addr  <= BASE_ADDR;
          end
        end
        S_HI: begin
          if (accept) begin
            hi_byte <= in_data;
            sum     <= sum + in_data;
          end
        end
        S_LO: begin
          // The RAM port registers are loaded here so they are valid during
          // WRITE and hold their value afterwards.
          if (accept) begin
            ram_wdata <= {hi_byte, in_data};
            ram_addr  <= addr;
            sum       <= sum + in_data;
          end
        end
        S_WRITE: begin
          addr  <= addr + ADDR_W'(1);
          count <= count - 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    ram_we     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_LEN: begin
        in_ready = 1'b1;
        if (accept) state_next = S_HI;
      end
      S_HI: begin
        in_ready = 1'b1;
        if (accept) state_next = S_LO;
      end
      S_LO: begin
        in_ready = 1'b1;
        if (accept) state_next = S_WRITE;
      end
      S_WRITE: begin
        ram_we = 1'b1;
        // LEN=0 starts count at 0 and wraps through FF..1, giving 256 words.
        state_next = (count == 8'd1) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        in_ready = 1'b1;
        if (accept) state_next = csum_ok(sum, in_data) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done = 1'b1;
        if (reload) state_next = S_LEN;
      end
      S_ERR: begin
        err = 1'b1;
        if (reload) state_next = S_LEN;
      end
      default: state_next = S_LEN;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        reload;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready0, ram_we0, cpu_rst0, done0, err0;
  logic [7:0]  ram_addr0;
  logic [15:0] ram_wdata0;
  logic        in_ready1, ram_we1, cpu_rst1, done1, err1;
  logic [7:0]  ram_addr1;
  logic [15:0] ram_wdata1;

  int vectors = 0;
  int miscompares = 0;
  int we_count = 0;
  bit gaps = 1'b0;
  bit seen0 [256];
  logic [15:0] img0 [256];
  logic [23:0] exp0 [$];
  logic [23:0] exp1 [$];
  logic [23:0] e0, e1;
  logic [15:0] wq [$];

  prog_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .reload(reload), .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
    .cpu_rst(cpu_rst0), .done(done0), .err(err0)
  );

  prog_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .reload(reload), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .cpu_rst(cpu_rst1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  // Scoreboard: every RAM write is popped against the expected queue.
  always @(negedge clk) begin
    if (ram_we0) begin
      we_count++;
      seen0[ram_addr0] = 1'b1;
      img0[ram_addr0] = ram_wdata0;
      vectors++;
      if (exp0.size() == 0) begin
        miscompares++;
        $display("FAIL write0_unexpected got addr=%h data=%h expected no write", ram_addr0, ram_wdata0);
      end else begin
        e0 = exp0.pop_front();
        if ({ram_addr0, ram_wdata0} !== e0) begin
          miscompares++;
          $display("FAIL write0 got %h:%h expected %h:%h", ram_addr0, ram_wdata0, e0[23:16], e0[15:0]);
        end
      end
    end
    if (ram_we1) begin
      vectors++;
      if (exp1.size() == 0) begin
        miscompares++;
        $display("FAIL write1_unexpected got addr=%h data=%h expected no write", ram_addr1, ram_wdata1);
      end else begin
        e1 = exp1.pop_front();
        if ({ram_addr1, ram_wdata1} !== e1) begin
          miscompares++;
          $display("FAIL write1 got %h:%h expected %h:%h", ram_addr1, ram_wdata1, e1[23:16], e1[15:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready0 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout got in_ready=%b expected 1", in_ready0);
    end
    @(negedge clk);
  endtask

  task automatic send_words(input logic [15:0] w[$], input logic [7:0] sum_in, output logic [7:0] sum_out);
    logic [7:0] s;
    s = sum_in;
    foreach (w[i]) begin
      s = s + w[i][15:8] + w[i][7:0];
      exp0.push_back({8'(8'h00 + i), w[i]});
      exp1.push_back({8'(8'hFE + i), w[i]});
      send_byte(w[i][15:8]);
      send_byte(w[i][7:0]);
      vectors++;
      if (ram_we0 !== 1'b1 || in_ready0 !== 1'b0) begin
        miscompares++;
        $display("FAIL write_latency got we=%b rdy=%b expected we=1 rdy=0", ram_we0, in_ready0);
      end
    end
    sum_out = s;
  endtask

  task automatic send_stream(input logic [15:0] w[$], input logic [7:0] corrupt);
    logic [7:0] len, s, csum;
    len = 8'(w.size());
    send_byte(len);
    send_words(w, len, s);
    csum = (8'h00 - s) + corrupt;
    vectors++;
    if (cpu_rst0 !== 1'b1) begin
      miscompares++;
      $display("FAIL cpu_rst_before_csum got %b expected 1", cpu_rst0);
    end
    send_byte(csum);
    in_valid = 1'b0;
    vectors++;
    if (corrupt == 8'h00) begin
      if ({done0, err0, cpu_rst0, in_ready0, done1} !== 5'b10001) begin
        miscompares++;
        $display("FAIL good_end got done=%b err=%b cpu_rst=%b rdy=%b done1=%b expected 1 0 0 0 1",
                 done0, err0, cpu_rst0, in_ready0, done1);
      end
    end else begin
      if ({done0, err0, cpu_rst0, in_ready0, err1} !== 5'b01101) begin
        miscompares++;
        $display("FAIL bad_end got done=%b err=%b cpu_rst=%b rdy=%b err1=%b expected 0 1 1 0 1",
                 done0, err0, cpu_rst0, in_ready0, err1);
      end
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    vectors++;
    if ({in_ready0, done0, err0, cpu_rst0} !== 4'b1001) begin
      miscompares++;
      $display("FAIL reload got rdy=%b done=%b err=%b cpu_rst=%b expected 1 0 0 1",
               in_ready0, done0, err0, cpu_rst0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cpu_rst0, in_ready0, ram_we0, done0, err0} !== 5'b11000 ||
        ram_addr0 !== 8'h00 || ram_addr1 !== 8'hFE || ram_wdata0 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset got cr=%b rdy=%b we=%b d=%b e=%b a0=%h a1=%h wd=%h expected 1 1 0 0 0 00 FE 0000",
               cpu_rst0, in_ready0, ram_we0, done0, err0, ram_addr0, ram_addr1, ram_wdata0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good();
    wq = {16'h0A05, 16'h0B00};
    send_stream(wq, 8'h00);
    do_reload();
  endtask

  task automatic test_bad();
    wq = {16'h0A05, 16'h0B00};
    send_stream(wq, 8'h01);
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({in_ready0, err0, cpu_rst0, ram_we0} !== 4'b0110) begin
      miscompares++;
      $display("FAIL err_hold got rdy=%b err=%b cpu_rst=%b we=%b expected 0 1 1 0",
               in_ready0, err0, cpu_rst0, ram_we0);
    end
    in_valid = 1'b0;
    do_reload();
  endtask

  task automatic test_wrap3();
    wq = {16'h1111, 16'h2222, 16'h3333};
    send_stream(wq, 8'h00);
    do_reload();
  endtask

  task automatic test_reload_ignored();
    logic [7:0] s;
    wq = {16'h1234};
    send_byte(8'h01);
    in_valid = 1'b0;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    send_words(wq, 8'h01, s);
    send_byte(8'h00 - s);
    in_valid = 1'b0;
    vectors++;
    if ({done0, cpu_rst0} !== 2'b10) begin
      miscompares++;
      $display("FAIL reload_ignored got done=%b cpu_rst=%b expected 1 0", done0, cpu_rst0);
    end
    do_reload();
  endtask

  task automatic test_full();
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back(16'($urandom));
    for (int i = 0; i < 256; i++) seen0[i] = 1'b0;
    we_count = 0;
    send_stream(wq, 8'h00);
    vectors++;
    if (we_count !== 256) begin
      miscompares++;
      $display("FAIL full_count got %0d expected 256", we_count);
    end
    for (int i = 0; i < 256; i++) begin
      vectors++;
      if (seen0[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL full_cover got addr %0d unwritten expected written", i);
      end
    end
    do_reload();
  endtask

  task automatic test_back_to_back();
    logic [15:0] snap [6];
    wq.delete();
    for (int i = 0; i < 6; i++) wq.push_back(16'($urandom));
    gaps = 1'b0;
    send_stream(wq, 8'h00);
    do_reload();
    for (int i = 0; i < 6; i++) begin
      snap[i] = img0[i];
      img0[i] = 16'hxxxx;
    end
    gaps = 1'b1;
    send_stream(wq, 8'h00);
    do_reload();
    gaps = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (img0[i] !== snap[i] || img0[i] !== wq[i]) begin
        miscompares++;
        $display("FAIL image addr=%0d got %h/%h expected %h", i, img0[i], snap[i], wq[i]);
      end
    end
  endtask

  task automatic test_abort();
    send_byte(8'h02);
    send_byte(8'hAA);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ram_we0, cpu_rst0, in_ready0, done0, err0} !== 5'b01100) begin
      miscompares++;
      $display("FAIL abort got we=%b cr=%b rdy=%b d=%b e=%b expected 0 1 1 0 0",
               ram_we0, cpu_rst0, in_ready0, done0, err0);
    end
    wq = {16'hC0DE, 16'h0042};
    send_stream(wq, 8'h00);
    do_reload();
  endtask

  initial begin
    rst = 1'b1;
    reload = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    test_reset();
    test_good();
    test_bad();
    test_wrap3();
    test_reload_ignored();
    test_full();
    test_back_to_back();
    test_abort();
    repeat (3) @(negedge clk);
    vectors++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      miscompares++;
      $display("FAIL pending_writes got %0d/%0d expected 0/0", exp0.size(), exp1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
